// File: rtl/mem_read_control.sv
// Capture-buffer readout: once capture completes, streams one header word per trigger followed
// by that trigger's samples, using a 2-entry output queue sized for a 1-cycle memory read latency.
module mem_read_control #(
  parameter int unsigned ADDR_W  = 16,
  parameter int unsigned DATA_W  = 16,
  parameter logic [7:0]  HDR_TAG = 8'hE0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        nwrite,
  input  logic [7:0]        ntrigger,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rd_data,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {StIdle, StHdr, StRd, StDrain, StFin} state_e;

  state_e            state_q, state_d;
  logic              start_prev_q, start_prev_d;
  logic [7:0]        nwrite_q, nwrite_d;
  logic [7:0]        ntrigger_q, ntrigger_d;
  logic [7:0]        evt_q, evt_d;
  logic [7:0]        smp_q, smp_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              inflight_q, inflight_d;
  logic              last_inflight_q, last_inflight_d;

  // Output queue entries are {last, data}.
  logic [DATA_W:0]   q_mem_q [2];
  logic [DATA_W:0]   q_mem_d [2];
  logic              wr_ptr_q, wr_ptr_d;
  logic              rd_ptr_q, rd_ptr_d;
  logic [1:0]        count_q, count_d;

  logic              pop;
  logic              push;
  logic              hdr_push;
  logic              rd_issue;
  logic              credit;
  logic              smp_last;
  logic [2:0]        occ;
  logic [8:0]        evt_next;
  logic [DATA_W-1:0] hdr_word;
  logic [DATA_W:0]   push_word;

  assign pop      = (count_q != 2'd0) && out_ready;
  // Occupancy seen by the next push: after this cycle's pop, plus any read landing now.
  assign occ      = {1'b0, count_q} - {2'b0, pop} + {2'b0, inflight_q};
  assign credit   = occ < 3'd2;
  assign smp_last = smp_q == (nwrite_q - 8'd1);
  assign evt_next = {1'b0, evt_q} + 9'd1;
  assign hdr_word = DATA_W'({HDR_TAG, evt_q});

  always_comb begin
    state_d         = state_q;
    start_prev_d    = start;
    nwrite_d        = nwrite_q;
    ntrigger_d      = ntrigger_q;
    evt_d           = evt_q;
    smp_d           = smp_q;
    rd_addr_d       = rd_addr_q;
    last_inflight_d = 1'b0;
    rd_issue        = 1'b0;
    hdr_push        = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start && !start_prev_q) begin
          nwrite_d   = nwrite;
          ntrigger_d = ntrigger;
          evt_d      = 8'd0;
          smp_d      = 8'd0;
          rd_addr_d  = '0;
          state_d    = (nwrite == 8'd0 || ntrigger == 8'd0) ? StFin : StHdr;
        end
      end
      StHdr: begin
        // The header waits out a landing sample so only one push happens per cycle.
        if (credit && !inflight_q) begin
          hdr_push = 1'b1;
          state_d  = StRd;
        end
      end
      StRd: begin
        if (credit && !rst) begin
          rd_issue  = 1'b1;
          rd_addr_d = rd_addr_q + ADDR_W'(1);
          if (smp_last) begin
            last_inflight_d = 1'b1;
            smp_d           = 8'd0;
            evt_d           = evt_next[7:0];
            state_d         = (evt_next < {1'b0, ntrigger_q}) ? StHdr : StDrain;
          end else begin
            smp_d = smp_q + 8'd1;
          end
        end
      end
      StDrain: begin
        if (count_q == 2'd0 && !inflight_q) state_d = StFin;
      end
      StFin: begin
        state_d = StFin;
      end
      default: state_d = StIdle;
    endcase
  end

  assign inflight_d = rd_issue;

  always_comb begin
    push      = hdr_push || inflight_q;
    push_word = inflight_q ? {last_inflight_q, rd_data} : {1'b0, hdr_word};
    q_mem_d   = q_mem_q;
    if (push) q_mem_d[wr_ptr_q] = push_word;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + {1'b0, push} - {1'b0, pop};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      start_prev_q    <= 1'b1;
      nwrite_q        <= 8'd0;
      ntrigger_q      <= 8'd0;
      evt_q           <= 8'd0;
      smp_q           <= 8'd0;
      rd_addr_q       <= '0;
      inflight_q      <= 1'b0;
      last_inflight_q <= 1'b0;
      q_mem_q[0]      <= '0;
      q_mem_q[1]      <= '0;
      wr_ptr_q        <= 1'b0;
      rd_ptr_q        <= 1'b0;
      count_q         <= 2'd0;
    end else begin
      state_q         <= state_d;
      start_prev_q    <= start_prev_d;
      nwrite_q        <= nwrite_d;
      ntrigger_q      <= ntrigger_d;
      evt_q           <= evt_d;
      smp_q           <= smp_d;
      rd_addr_q       <= rd_addr_d;
      inflight_q      <= inflight_d;
      last_inflight_q <= last_inflight_d;
      q_mem_q         <= q_mem_d;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
    end
  end

  assign rd_en                = rd_issue;
  assign rd_addr              = rd_addr_q;
  assign out_valid            = count_q != 2'd0;
  assign {out_last, out_data} = q_mem_q[rd_ptr_q];
  assign busy                 = (state_q == StHdr) || (state_q == StRd) || (state_q == StDrain);
  assign done                 = state_q == StFin;

endmodule
